// File: rtl/mcac_pkg.sv
// Shared definitions for the multichannel codec predictor path: scheduler
// states, default channel geometry and the delay-strobe length.
package mcac_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_START,
        S_WAIT,
        S_STROBE,
        S_NEXT
    } sched_state_t;

    localparam int NUM_CH_DEF = 4;
    localparam int CH_W_DEF   = 2;

    // Must match the number of delay-register update cycles in the datapath.
    localparam int PRED_DLY_CYC = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/adap_pred_prio_enc.sv
// Lowest-set-bit encoder: picks the lowest-numbered requesting channel.
module adap_pred_prio_enc
    import mcac_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CH_W   = CH_W_DEF
) (
    input  logic [NUM_CH-1:0] req,
    output logic [CH_W-1:0]   idx,
    output logic              valid
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        idx   = '0;
        valid = 1'b0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = CH_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adap_pred_sched.sv
// Time-share scheduler: on each frame strobe runs the shared predictor once
// per requesting channel, in ascending order, then commits its delay state.
module adap_pred_sched
    import mcac_pkg::*;
#(
    parameter int NUM_CH  = NUM_CH_DEF,
    parameter int CH_W    = CH_W_DEF,
    parameter int TIMEOUT = 200,
    parameter int DLY_CYC = PRED_DLY_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_strb,
    input  logic [NUM_CH-1:0] ch_req,
    input  logic              pred_done,
    output logic              start_trig,
    output logic              dly_strb,
    output logic [CH_W-1:0]   ch_sel,
    output logic              ch_done,
    output logic [CH_W-1:0]   ch_done_id,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err
);

    // One counter serves both the done timeout and the strobe length.
    localparam int CNT_W = $clog2(max_int(TIMEOUT, DLY_CYC)) + 1;
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DLY_CYC - 1);

    sched_state_t      state;
    logic [NUM_CH-1:0] pending;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CH_W-1:0]   enc_idx;
    logic              enc_valid;

    adap_pred_prio_enc #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_prio_enc (
        .req   (pending),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; it is sampled only on a rising clk edge.
        if (!reset) begin
            state       <= S_IDLE;
            pending     <= '0;
            wait_cnt    <= '0;
            start_trig  <= 1'b0;
            dly_strb    <= 1'b0;
            ch_sel      <= '0;
            ch_done     <= 1'b0;
            ch_done_id  <= '0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            start_trig <= 1'b0;
            ch_done    <= 1'b0;

            // A frame is only accepted in IDLE; anything else is an overrun.
            if (frame_strb && state != S_IDLE) begin
                overrun <= 1'b1;
            end

            unique case (state)
                S_IDLE: begin
                    if (frame_strb) begin
                        pending <= ch_req;
                        if (|ch_req) begin
                            busy  <= 1'b1;
                            state <= S_ARB;
                        end
                    end
                end

                S_ARB: begin
                    if (enc_valid) begin
                        ch_sel     <= enc_idx;
                        start_trig <= 1'b1;
                        state      <= S_START;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                S_START: begin
                    pending  <= pending & ~(NUM_CH'(1) << ch_sel);
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end

                S_WAIT: begin
                    // Done wins over the timeout on the last counted cycle.
                    if (pred_done) begin
                        ch_done    <= 1'b1;
                        ch_done_id <= ch_sel;
                        dly_strb   <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= S_STROBE;
                    end else if (wait_cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_NEXT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                S_STROBE: begin
                    if (wait_cnt == DLY_LAST) begin
                        dly_strb <= 1'b0;
                        state    <= S_NEXT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                S_NEXT: begin
                    state <= S_ARB;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adap_pred_sched.sv
// Directed bench for adap_pred_sched: per-frame event capture compared
// against hand-derived cycle numbers (frame_strb driven in cycle 0).
module tb_adap_pred_sched;

    logic       clk;
    logic       reset;
    logic       frame_strb;
    logic [3:0] ch_req;
    logic       pred_done;
    logic       start_trig;
    logic       dly_strb;
    logic [1:0] ch_sel;
    logic       ch_done;
    logic [1:0] ch_done_id;
    logic       busy;
    logic       overrun;
    logic       timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    // Events captured by run_frame, indexed by cycle relative to frame_strb.
    int start_cyc[$];
    int start_ch[$];
    int done_cyc[$];
    int done_id[$];
    int strb_cyc[$];
    int busy_low;
    int to_cyc;
    int ovr_cyc;

    adap_pred_sched #(
        .NUM_CH  (4),
        .CH_W    (2),
        .TIMEOUT (200),
        .DLY_CYC (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_strb  (frame_strb),
        .ch_req      (ch_req),
        .pred_done   (pred_done),
        .start_trig  (start_trig),
        .dly_strb    (dly_strb),
        .ch_sel      (ch_sel),
        .ch_done     (ch_done),
        .ch_done_id  (ch_done_id),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 100000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one frame and watch ncyc cycles. pred_done answers lat cycles
    // after each start_trig unless the channel is in no_done. Optionally a
    // second strobe at ovr_at and a stray pred_done at spur_at.
    task automatic run_frame(input logic [3:0] req, input logic [3:0] no_done,
                             input int lat, input int ovr_at, input logic [3:0] ovr_req,
                             input int spur_at, input int ncyc);
        int due;
        due = -1;
        start_cyc.delete(); start_ch.delete();
        done_cyc.delete();  done_id.delete();
        strb_cyc.delete();
        busy_low = -1; to_cyc = -1; ovr_cyc = -1;
        frame_strb = 1'b1;
        ch_req     = req;
        pred_done  = 1'b0;
        for (int n = 1; n <= ncyc; n++) begin
            tick();
            frame_strb = 1'b0;
            pred_done  = 1'b0;
            if (start_trig) begin
                start_cyc.push_back(n);
                start_ch.push_back(int'(ch_sel));
                if (!no_done[ch_sel]) due = n + lat;
            end
            if (ch_done) begin
                done_cyc.push_back(n);
                done_id.push_back(int'(ch_done_id));
            end
            if (dly_strb) strb_cyc.push_back(n);
            if (!busy && busy_low < 0) busy_low = n;
            if (timeout_err && to_cyc < 0) to_cyc = n;
            if (overrun && ovr_cyc < 0) ovr_cyc = n;
            if (n == due || n == spur_at) pred_done = 1'b1;
            if (n == ovr_at) begin
                frame_strb = 1'b1;
                ch_req     = ovr_req;
            end
        end
        frame_strb = 1'b0;
        pred_done  = 1'b0;
    endtask

    initial begin
        int acts;
        reset      = 1'b0;
        frame_strb = 1'b0;
        ch_req     = 4'b0000;
        pred_done  = 1'b0;
        tick();
        tick();
        check("reset_outputs", int'({start_trig, dly_strb, ch_sel, ch_done, ch_done_id,
                                     busy, overrun, timeout_err}), 0);
        reset = 1'b1;
        tick();

        // Single channel, done 5 cycles after start.
        run_frame(4'b0001, 4'b0000, 5, -1, 4'b0000, -1, 20);
        check("single_start_cnt", start_cyc.size(), 1);
        check("single_start_cyc", qget(start_cyc, 0), 2);
        check("single_ch_sel",    qget(start_ch, 0), 0);
        check("single_done_cnt",  done_cyc.size(), 1);
        check("single_done_cyc",  qget(done_cyc, 0), 8);
        check("single_done_id",   qget(done_id, 0), 0);
        check("single_strb_cnt",  strb_cyc.size(), 2);
        check("single_strb_first", qget(strb_cyc, 0), 8);
        check("single_strb_last",  qget(strb_cyc, 1), 9);
        check("single_busy_low",  busy_low, 12);

        // Channels 0,1,3; each slot is 10 cycles.
        run_frame(4'b1011, 4'b0000, 5, -1, 4'b0000, -1, 40);
        check("multi_start_cnt", start_cyc.size(), 3);
        check("multi_start1_cyc", qget(start_cyc, 1), 12);
        check("multi_start2_cyc", qget(start_cyc, 2), 22);
        check("multi_sel0", qget(start_ch, 0), 0);
        check("multi_sel1", qget(start_ch, 1), 1);
        check("multi_sel2", qget(start_ch, 2), 3);
        check("multi_done_cnt", done_cyc.size(), 3);
        check("multi_id0", qget(done_id, 0), 0);
        check("multi_id1", qget(done_id, 1), 1);
        check("multi_id2", qget(done_id, 2), 3);
        check("multi_done2_cyc", qget(done_cyc, 2), 28);
        check("multi_strb_cnt", strb_cyc.size(), 6);
        check("multi_busy_low", busy_low, 32);

        // Channel 0 never answers: WAIT cycles 3..202, flag at 203.
        run_frame(4'b0011, 4'b0001, 5, -1, 4'b0000, -1, 230);
        check("to_flag_cyc",   to_cyc, 203);
        check("to_start_cnt",  start_cyc.size(), 2);
        check("to_start1_cyc", qget(start_cyc, 1), 205);
        check("to_sel1",       qget(start_ch, 1), 1);
        check("to_done_cnt",   done_cyc.size(), 1);
        check("to_done_id",    qget(done_id, 0), 1);
        check("to_done_cyc",   qget(done_cyc, 0), 211);
        check("to_strb_first", qget(strb_cyc, 0), 211);
        check("to_strb_cnt",   strb_cyc.size(), 2);
        check("to_no_overrun", int'(overrun), 0);

        // Second strobe during channel 1 WAIT, requesting channel 2.
        run_frame(4'b0011, 4'b0000, 5, 14, 4'b0100, -1, 40);
        check("ovr_flag_cyc",  ovr_cyc, 15);
        check("ovr_start_cnt", start_cyc.size(), 2);
        check("ovr_done_cnt",  done_cyc.size(), 2);
        check("ovr_id1",       qget(done_id, 1), 1);
        check("ovr_busy_low",  busy_low, 22);
        check("ovr_timeout_sticky", int'(timeout_err), 1);

        // Reset during STROBE (cycle 8) with both sticky flags set.
        frame_strb = 1'b1;
        ch_req     = 4'b0001;
        for (int n = 1; n <= 8; n++) begin
            tick();
            frame_strb = 1'b0;
            pred_done  = (n == 7);
        end
        check("rst_in_strobe", int'(dly_strb), 1);
        pred_done = 1'b0;
        reset     = 1'b0;
        tick();
        check("rst_mid_outputs", int'({start_trig, dly_strb, ch_sel, ch_done, ch_done_id,
                                       busy, overrun, timeout_err}), 0);
        reset = 1'b1;
        acts  = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (dly_strb || ch_done || start_trig || busy) acts++;
        end
        check("rst_quiet_after", acts, 0);
        run_frame(4'b0100, 4'b0000, 5, -1, 4'b0000, -1, 20);
        check("rst_resume_sel",  qget(start_ch, 0), 2);
        check("rst_resume_done", qget(done_cyc, 0), 8);
        check("rst_resume_id",   qget(done_id, 0), 2);

        // Empty frame plus a stray pred_done while idle.
        run_frame(4'b0000, 4'b0000, 5, -1, 4'b0000, 3, 12);
        check("empty_busy_low",  busy_low, 1);
        check("empty_start_cnt", start_cyc.size(), 0);
        check("empty_done_cnt",  done_cyc.size(), 0);
        check("empty_strb_cnt",  strb_cyc.size(), 0);
        check("empty_no_flags",  int'({overrun, timeout_err}), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
